// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode codes, adder latency and flag bit positions.
package fpu_pkg;

  typedef enum logic [2:0] {
    RNe = 3'b000,
    RZ  = 3'b001,
    RD  = 3'b010,
    RU  = 3'b011,
    RNa = 3'b100
  } round_mode_e;

  localparam int FPADD_LAT = 2;

  localparam int FLAG_OV  = 3;
  localparam int FLAG_UN  = 2;
  localparam int FLAG_INV = 1;
  localparam int FLAG_NX  = 0;

  localparam logic [31:0] FP_NANQ = 32'h7FC0_0000;

  function automatic logic [3:0] pack_flags(input logic ov, input logic un,
                                            input logic inv, input logic nx);
    logic [3:0] f;
    f           = 4'b0000;
    f[FLAG_OV]  = ov;
    f[FLAG_UN]  = un;
    f[FLAG_INV] = inv;
    f[FLAG_NX]  = nx;
    return f;
  endfunction

endpackage

// File: rtl/fpadd_arbiter_rr_arb.sv
// Round-robin grant logic: the first requester at or after the pointer wins,
// and the pointer moves one past the winner whenever a grant is issued.
module rr_arb #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] r_ptr;
  logic           w_found;
  logic           w_hit;
  int             w_idx;

  // Rotating search for the first active request starting at the pointer
  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    w_hit    = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < N; k++) begin
      w_idx        = (int'(r_ptr) + k) % N;
      w_hit        = en & ~w_found & req[w_idx];
      grant[w_idx] = grant[w_idx] | w_hit;
      grant_id     = w_hit ? IDW'(w_idx) : grant_id;
      w_found      = w_found | w_hit;
    end
  end

  // Pointer advance on every issued grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/fpadd_arbiter.sv
// Shares one external fp_add among N requesters: round-robin issue, tag pipeline, result routing.
// Optional FPADD_ARB_STICKY_FLAGS_EN adds per-requester sticky exception flags.
module fpadd_arbiter
  import fpu_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
`ifdef FPADD_ARB_STICKY_FLAGS_EN
  input  logic [N-1:0]   flag_clr,
  output logic [N*4-1:0] sticky_flags,
`endif
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N*3-1:0] req_rm,
  input  logic           hold,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_out,
  output logic [3:0]     rsp_flags,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   fpu_in1,
  output logic [W-1:0]   fpu_in2,
  output logic [2:0]     fpu_round_m,
  output logic           fpu_act,
  input  logic [W-1:0]   fpu_out,
  input  logic           fpu_ov,
  input  logic           fpu_un,
  input  logic           fpu_inv,
  input  logic           fpu_inexact
);

  logic [N-1:0]   w_grant;
  logic [IDW-1:0] w_gid;
  logic           w_en;
  logic           w_xfer;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [2:0]       r_rm;
  logic [FPADD_LAT:0] r_tv;
  logic [IDW-1:0]   r_tid [FPADD_LAT+1];

  // Reset also masks grants so nothing is accepted while the pipeline is cleared
  assign w_en   = ~hold & rst;
  assign w_xfer = |(w_grant & req_valid);

  rr_arb #(.N(N), .IDW(IDW)) u_rr_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .en       (w_en),
    .grant    (w_grant),
    .grant_id (w_gid)
  );

  assign req_ready = w_grant;

  // Issue registers plus tag shift chain aligned to the adder latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_rm <= 3'b000;
      r_tv <= '0;
      for (int s = 0; s <= FPADD_LAT; s++) r_tid[s] <= '0;
    end else begin
      r_tv[0] <= w_xfer;
      if (w_xfer) begin
        r_a      <= req_a[w_gid*W +: W];
        r_b      <= req_b[w_gid*W +: W];
        r_rm     <= req_rm[w_gid*3 +: 3];
        r_tid[0] <= w_gid;
      end
      for (int s = 1; s <= FPADD_LAT; s++) begin
        r_tv[s]  <= r_tv[s-1];
        r_tid[s] <= r_tid[s-1];
      end
    end
  end

  assign fpu_in1     = r_a;
  assign fpu_in2     = r_b;
  assign fpu_round_m = r_rm;
  assign fpu_act     = r_tv[0];

  // Route the completed result strobe to the tagged requester
  always_comb begin
    rsp_valid = '0;
    if (r_tv[FPADD_LAT]) begin
      rsp_valid[r_tid[FPADD_LAT]] = 1'b1;
    end else begin
      rsp_valid = '0;
    end
  end

  assign rsp_out   = fpu_out;
  assign rsp_flags = pack_flags(fpu_ov, fpu_un, fpu_inv, fpu_inexact);
  assign rsp_id    = r_tid[FPADD_LAT];

`ifdef FPADD_ARB_STICKY_FLAGS_EN
  logic [N*4-1:0] r_sticky;

  // Sticky flags: a response landing together with a clear keeps only the new flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sticky <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          r_sticky[i*4 +: 4] <= rsp_flags | (flag_clr[i] ? 4'b0000 : r_sticky[i*4 +: 4]);
        end else if (flag_clr[i]) begin
          r_sticky[i*4 +: 4] <= 4'b0000;
        end
      end
    end
  end

  assign sticky_flags = r_sticky;
`endif

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Randomized self-checking bench for fpadd_arbiter with a stand-in two-stage adder.
module tb_fpadd_arbiter;
  import fpu_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N*3-1:0] req_rm = '0;
  logic           hold = 1'b0;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_out;
  logic [3:0]     rsp_flags;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   fpu_in1, fpu_in2, fpu_out;
  logic [2:0]     fpu_round_m;
  logic           fpu_act, fpu_ov, fpu_un, fpu_inv, fpu_inexact;
`ifdef FPADD_ARB_STICKY_FLAGS_EN
  logic [N-1:0]   flag_clr = '0;
  logic [N*4-1:0] sticky_flags;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpadd_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
`ifdef FPADD_ARB_STICKY_FLAGS_EN
    .flag_clr(flag_clr), .sticky_flags(sticky_flags),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_rm(req_rm), .hold(hold), .rsp_valid(rsp_valid), .rsp_out(rsp_out),
    .rsp_flags(rsp_flags), .rsp_id(rsp_id), .fpu_in1(fpu_in1), .fpu_in2(fpu_in2),
    .fpu_round_m(fpu_round_m), .fpu_act(fpu_act), .fpu_out(fpu_out), .fpu_ov(fpu_ov),
    .fpu_un(fpu_un), .fpu_inv(fpu_inv), .fpu_inexact(fpu_inexact)
  );

  // Stand-in adder: two known IEEE cases, otherwise a deterministic mix; result is {flags, value}
  function automatic logic [35:0] stub_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] rm);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {4'b0000, 32'h4040_0000};
    else if (a == 32'h7F80_0000 && b == 32'hFF80_0000) return {4'b0010, FP_NANQ};
    else return {a[3:0] ^ b[7:4], a + b + {29'd0, rm}};
  endfunction

  logic [35:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= stub_add(fpu_in1, fpu_in2, fpu_round_m);
    s2 <= s1;
  end
  assign fpu_out = s2[31:0];
  assign {fpu_ov, fpu_un, fpu_inv, fpu_inexact} = s2[35:32];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected responses are scheduled three cycles after each grant
  int          m_ptr = 0;
  int          cyc = 0;
  logic        m_v [8];
  int          m_id [8];
  logic [35:0] m_res [8];
  logic        m_act = 1'b0;
  logic [3:0]  m_sticky [N];
  int          slot, g, nx;
  logic [N-1:0] exp_rv;

  initial begin
    for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
    for (int i = 0; i < N; i++) m_sticky[i] = 4'b0000;
  end

  always @(negedge clk) begin
    slot = cyc % 8;
    if (!rst) begin
      m_ptr = 0;
      m_act = 1'b0;
      for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
      for (int i = 0; i < N; i++) m_sticky[i] = 4'b0000;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_fpu_act", 64'(fpu_act), 64'd0);
    end else begin
      exp_rv = m_v[slot] ? (4'b0001 << m_id[slot]) : 4'b0000;
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (m_v[slot]) begin
        chk("rsp_out", 64'(rsp_out), 64'(m_res[slot][31:0]));
        chk("rsp_flags", 64'(rsp_flags), 64'(m_res[slot][35:32]));
        chk("rsp_id", 64'(rsp_id), 64'(m_id[slot]));
      end
      chk("fpu_act", 64'(fpu_act), 64'(m_act));
`ifdef FPADD_ARB_STICKY_FLAGS_EN
      for (int i = 0; i < N; i++) begin
        chk("sticky", 64'(sticky_flags[i*4 +: 4]), 64'(m_sticky[i]));
        if (flag_clr[i]) m_sticky[i] = 4'b0000;
        if (m_v[slot] && m_id[slot] == i) m_sticky[i] = m_sticky[i] | m_res[slot][35:32];
      end
`endif
      m_v[slot] = 1'b0;
      g = -1;
      if (!hold) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      m_act = (g >= 0);
      if (g >= 0) begin
        nx        = (cyc + 3) % 8;
        m_v[nx]   = 1'b1;
        m_id[nx]  = g;
        m_res[nx] = stub_add(req_a[g*W +: W], req_b[g*W +: W], req_rm[g*3 +: 3]);
        m_ptr     = (g + 1) % N;
      end
    end
    cyc++;
  end

  int hits;
  logic [35:0] want;

  initial begin
    repeat (3) step();
    rst = 1'b1;
    step();

    // All four continuously valid from reset: strict rotation 0,1,2,3,0
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = $urandom;
      req_b[i*W +: W] = $urandom;
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rotation_grant", 64'(req_ready), 64'd1 << (k % 4));
      step();
    end
    req_valid = '0;
    repeat (4) step();

    // 1.0 + 2.0 from requester 2 appears three cycles later as 3.0
    req_a[2*W +: W] = 32'h3F80_0000;
    req_b[2*W +: W] = 32'h4000_0000;
    req_rm[2*3 +: 3] = RNe;
    req_valid = 4'b0100;
    repeat (3) begin step(); req_valid = '0; end
    chk("single_valid", 64'(rsp_valid), 64'h4);
    chk("single_out", 64'(rsp_out), 64'h4040_0000);
    chk("single_flags", 64'(rsp_flags), 64'd0);
    step();

    // +inf + -inf from requester 0 gives quiet NaN with invalid set
    req_a[0 +: W] = 32'h7F80_0000;
    req_b[0 +: W] = 32'hFF80_0000;
    req_valid = 4'b0001;
    repeat (3) begin step(); req_valid = '0; end
    chk("nan_valid", 64'(rsp_valid), 64'h1);
    chk("nan_out", 64'(rsp_out), 64'(FP_NANQ));
    chk("nan_inv", 64'(rsp_flags[FLAG_INV]), 64'd1);
    step();

    // Pointer now at 1: requesters 1 and 3 alternate, hold blocks three cycles, then 1 resumes
    req_valid = 4'b1010;
    #1; chk("hold_pre0", 64'(req_ready), 64'b0010); step();
    #1; chk("hold_pre1", 64'(req_ready), 64'b1000); step();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; chk("hold_blocked", 64'(req_ready), 64'd0); step();
    end
    hold = 1'b0;
    #1; chk("hold_resume", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    repeat (4) step();

    // Reset right after two grants discards both operations
    req_valid = 4'b0001; step();
    req_valid = 4'b0010; step();
    req_valid = '0;
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    hits = 0;
    repeat (5) begin
      if (rsp_valid != '0) hits++;
      step();
    end
    chk("rst_discard", 64'(hits), 64'd0);
    req_a[3*W +: W] = 32'h1234_5678;
    req_b[3*W +: W] = 32'h0000_00F0;
    req_rm[3*3 +: 3] = RU;
    want = stub_add(32'h1234_5678, 32'h0000_00F0, RU);
    req_valid = 4'b1000;
    repeat (3) begin step(); req_valid = '0; end
    chk("post_rst_valid", 64'(rsp_valid), 64'h8);
    chk("post_rst_out", 64'(rsp_out), 64'(want[31:0]));
    step();

    // Randomized traffic checked cycle by cycle by the model
    for (int c = 0; c < 500; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = $urandom;
        req_b[i*W +: W] = $urandom;
        req_rm[i*3 +: 3] = 3'($urandom_range(0, 4));
      end
`ifdef FPADD_ARB_STICKY_FLAGS_EN
      flag_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
`endif
      step();
    end
    req_valid = '0;
    hold = 1'b0;
    repeat (4) step();

`ifdef FPADD_ARB_STICKY_FLAGS_EN
    // Inexact for requester 1, then a clear coinciding with a second inexact response
    flag_clr = 4'hF; step(); flag_clr = '0;
    req_a[1*W +: W] = 32'h0000_0001;
    req_b[1*W +: W] = 32'h0000_0000;
    req_valid = 4'b0010;
    repeat (4) begin step(); req_valid = '0; end
    chk("sticky_first", 64'(sticky_flags[7:4]), 64'b0001);
    req_valid = 4'b0010;
    repeat (3) begin step(); req_valid = '0; end
    flag_clr = 4'b0010;
    step();
    flag_clr = '0;
    chk("sticky_set_wins", 64'(sticky_flags[7:4]), 64'b0001);
    repeat (2) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fpadd_arbiter.md
# fpadd_arbiter

Round-robin scheduler that shares one `fp_add` instance among `N` requesters. Each requester presents two 32-bit operands and a rounding mode over a valid/ready handshake. The arbiter registers the granted operation into an issue stage and tags it with the requester ID. It then routes the adder result and exception flags back to the originating requester. It sits between the FPU-using client blocks and the single adder datapath, sustaining one operation per cycle.

## Interface
- `N`, default 4: number of requesters, from 2 to 8.
- `W`, default 32: operand width.
- `IDW`, default `$clog2(N)`: tag width.
- `clk` input, 1 bit: the only clock; all state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, `N` bits: per-requester request strobe.
- `req_ready` output, `N` bits: one-hot grant, or all zero.
- `req_a` input, `N*W` bits: first operand; requester `i` uses slice `[i*W +: W]`.
- `req_b` input, `N*W` bits: second operand, sliced the same way.
- `req_rm` input, `N*3` bits: rounding mode for each requester.
- `hold` input, 1 bit: when high, no new grants; in-flight operations drain.
- `rsp_valid` output, `N` bits: one-hot result strobe.
- `rsp_out` output, `W` bits: shared result bus.
- `rsp_flags` output, 4 bits: `{ov, un, inv, inexact}`.
- `rsp_id` output, `IDW` bits: tag of the current result.
- `fpu_in1`, `fpu_in2` output, `W` bits each: operands to the adder.
- `fpu_round_m` output, 3 bits: rounding mode to the adder.
- `fpu_act` output, 1 bit: high while the issue stage holds a valid operation.
- `fpu_out` input, `W` bits: adder result.
- `fpu_ov`, `fpu_un`, `fpu_inv`, `fpu_inexact` input, 1 bit each: adder flags.

## Operation
**Arbitration**
- Round-robin with a priority pointer `ptr`.
- The first requester at or after `ptr` (wrapping modulo `N`) with `req_valid` high is granted.
- `req_ready` is combinational from `req_valid`, `ptr` and `hold`; only the granted requester sees it high.
- A transfer occurs when `req_valid[i] && req_ready[i]`.
- On a transfer, `ptr` becomes `grant+1` modulo `N`; otherwise `ptr` is unchanged.
- With `hold` high, or with no request valid, `req_ready` is 0 and `ptr` is unchanged.

**Issue stage**
- On a transfer, the issue registers load the granted requester's `req_a`, `req_b` and `req_rm`, plus the tag `{1, id}`.
- Without a transfer, the tag valid bit clears and the operand registers keep their values, so the adder inputs stay stable.
- `fpu_in1`, `fpu_in2` and `fpu_round_m` come directly from the issue registers.
- `fpu_act` equals the issue-stage valid bit.

**Tag pipeline**
- Valid bit and ID shift through two further stages, matching the adder's fixed two-register latency.
- Adder `done` is not used: its value is inconsistent across the forwarded and normal paths, so the tag valid bit is the sole completion indicator.

**Response**
- When the last tag stage is valid: `rsp_valid[id]` is 1, and `rsp_out`, `rsp_flags` and `rsp_id` carry the adder outputs and the tag, all combinational from `fpu_*` and the tag register.
- When the last tag stage is not valid: `rsp_valid` is 0, while `rsp_out`/`rsp_flags` still follow `fpu_*` (don't-care) and `rsp_id` shows the last tag.
- Responses cannot be back-pressured; every requester must accept in the cycle presented.

**Reset**
- All outputs and state go to 0: `ptr`, tag valids and IDs, issue registers, `req_ready`, `rsp_valid`, `fpu_act`.
- A reset mid-operation discards in-flight operations; no response is produced for them.

## Timing
- Request accepted in cycle n → `fpu_*` inputs valid in cycle n+1 → `rsp_valid` high in cycle n+3. The latency is a fixed 3 cycles.
- Throughput is one operation per cycle.
- Back-to-back grants to the same requester are allowed only when no other requester is valid.
- With `K` requesters continuously valid, each is granted exactly once every `K` cycles.
- `hold` rising in cycle n blocks the grant in cycle n; responses for earlier grants still arrive on schedule.

## Configuration
- `FPADD_ARB_STICKY_FLAGS_EN` defined:
  - Adds output `sticky_flags` (`N*4` bits) and input `flag_clr` (`N` bits).
  - Each requester's 4 sticky bits OR in `rsp_flags` whenever its `rsp_valid` is high.
  - `flag_clr[i]` zeroes slice `i` on the next edge.
  - If a clear and a response hit the same slice in the same cycle, the slice takes the new response flags (the set wins).
  - Sticky bits reset to 0.
- Macro undefined: these ports and registers are absent; behaviour is otherwise identical.

## Structure
- Shared package or include file `fpu_pkg`:
  - rounding-mode codes `RNe`/`RZ`/`RU`/`RD`/`RNa`;
  - `FPADD_LAT = 2` (adder latency);
  - the flag bit positions within `rsp_flags`.
- Sub-module `rr_arb` (parameter `N`; ports `req`, `en`, `grant` one-hot, `ptr` update): pure round-robin grant logic with its pointer register.
- The top level instantiates `rr_arb`, the issue registers and the tag pipeline.
- The `fp_add` instance is external; the arbiter connects to it only through the `fpu_*` ports.

## Test plan
- Single op: requester 2 sends `0x3F800000 + 0x40000000`, `rm=RNe`, at cycle 5 → `rsp_valid=4'b0100` at cycle 8, `rsp_out=0x40400000`, flags 0.
- All four requesters continuously valid from reset, `ptr=0` → grants 0,1,2,3,0,1… one per cycle; each response arrives 3 cycles after its grant with the matching `rsp_id`.
- Requesters 1 and 3 valid, `hold` high for cycles 10–12 → no `req_ready` in cycles 10–12; grant resumes in cycle 13 at the requester following the last one granted.
- Requester 0 sends `0x7F800000 + 0xFF800000` → at +3 cycles `rsp_out=FP_NANQ`, `inv=1`.
- Assert `rst` one cycle after two grants → `rsp_valid` never asserts for either; after release, a new request completes with 3-cycle latency.
- With `FPADD_ARB_STICKY_FLAGS_EN`: an inexact result for requester 1, then `flag_clr[1]` coinciding with a second inexact response → `sticky_flags[7:4]=4'b0001` remains set.
